// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a fall-through FIFO and sends each as a UART frame on o_tx.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign o_fifo_rd_en = (state_q == ST_IDLE) & i_enable & ~i_fifo_empty & ~i_rst;
    assign o_tx         = tx_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = done_q;
    assign bit_end      = (cnt_q == CNT_LAST);

    // tx_d is the value the line holds for the whole next bit, so o_tx comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (o_fifo_rd_en) begin
                    shift_d = i_fifo_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_d = ^i_fifo_data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_d[0];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, line-capture monitor and a scoreboard of
// hand-derived frame bit sequences.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PBIT   = 1;
    localparam int PERIOD = 45;
`else
    localparam int PBIT   = 0;
    localparam int PERIOD = 41;
`endif
    localparam int FBITS = 10 + PBIT;
    localparam int FCYC  = FBITS * CPB;

    // seq: start, 8 data bits in line order, stop -- bit 9 goes out first
    typedef struct {
        logic [7:0] word;
        logic [9:0] seq;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       empty;
    logic [7:0] fdata;
    logic       rd_en, tx, busy, fdone;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(empty), .i_fifo_data(fdata),
        .o_fifo_rd_en(rd_en), .o_tx(tx), .o_busy(busy), .o_frame_done(fdone)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] fifo_q[$];
    vec_t sb[$];
    int   pop_cyc[$];
    vec_t tbl[7];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function void upd();
        empty = (fifo_q.size() == 0);
        if (!empty) fdata = fifo_q[0];
    endfunction

    function automatic logic [63:0] exp_line(vec_t r);
        logic [63:0] v;
        int j;
        v = '0;
        for (int c = 0; c < FCYC; c++) begin
            j = c / CPB;
            if (j < 9)                    v[c] = r.seq[9-j];
            else if (PBIT == 1 && j == 9) v[c] = r.par;
            else                          v[c] = 1'b1;
        end
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // FIFO pops one word per rd_en seen at the preceding negedge
    logic pop_next = 1'b0;
    always @(posedge clk) begin
        #1;
        if (pop_next && fifo_q.size() > 0) begin
            fifo_q.delete(0);
            upd();
        end
    end

    // Line monitor: captures each frame cycle by cycle after a pop and compares it whole.
    int          mon_cyc = -1;
    int          bad = 0;
    int          frames_done = 0;
    vec_t        cur;
    logic [63:0] cap;
    always @(negedge clk) begin
        if (rst) begin
            mon_cyc  = -1;
            pop_next = 1'b0;
        end else begin
            if (mon_cyc >= 0) begin
                mon_cyc++;
                if (mon_cyc <= FCYC) begin
                    cap[mon_cyc-1] = tx;
                    if (!busy || rd_en || fdone) bad++;
                end else begin
                    check("frame_line", cap, exp_line(cur));
                    check("frame_busy_rd_done", bad, 0);
                    check("frame_done_pulse", fdone, 1'b1);
                    check("frame_end_busy", busy, 1'b0);
                    frames_done++;
                    mon_cyc = -1;
                end
            end else begin
                check("idle_frame_done", fdone, 1'b0);
            end
            pop_next = rd_en;
            if (rd_en) begin
                check("pop_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) cur = sb.pop_front();
                mon_cyc = 0;
                bad     = 0;
                cap     = '0;
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(vec_t r);
        fifo_q.push_back(r.word);
        sb.push_back(r);
        upd();
    endtask

    task automatic wait_frames(int n, string nm);
        int t = 0;
        while (frames_done < n && t < 400) begin
            @(posedge clk);
            t++;
        end
        #2;
        check(nm, frames_done >= n, 1'b1);
    endtask

    task automatic wait_busy(string nm);
        int t = 0;
        while (!busy && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(nm, busy, 1'b1);
    endtask

    initial begin
        int base;
        int idle_bad;
        tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
        tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
        tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
        tbl[3] = '{8'h55, 10'b0101010101, 1'b0};
        tbl[4] = '{8'h07, 10'b0111000001, 1'b1};
        tbl[5] = '{8'h80, 10'b0000000011, 1'b1};
        tbl[6] = '{8'h3C, 10'b0001111001, 1'b0};

        rst = 1'b1; en = 1'b1; empty = 1'b1; fdata = '0;
        push(tbl[0]);
        tick(3);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_frame_done", fdone, 1'b0);
        rst = 1'b0;
        wait_frames(1, "first_frame_timeout");

        for (int i = 0; i < 7; i++) begin
            tick(1);
            base = frames_done;
            push(tbl[i]);
            wait_frames(base + 1, "table_frame_timeout");
        end

        tick(2);
        pop_cyc.delete();
        base = frames_done;
        push(tbl[1]); push(tbl[2]); push(tbl[3]);
        wait_frames(base + 3, "b2b_timeout");
        check("b2b_pop_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("b2b_period_1", pop_cyc[1] - pop_cyc[0], PERIOD);
            check("b2b_period_2", pop_cyc[2] - pop_cyc[1], PERIOD);
        end

        tick(1);
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (rd_en || !tx || busy) idle_bad++;
        end
        check("idle_empty_violations", idle_bad, 0);

        tick(1);
        base = frames_done;
        push(tbl[6]); push(tbl[5]);
        wait_busy("en_drop_busy");
        repeat (12) @(posedge clk);
        #2;
        en = 1'b0;
        wait_frames(base + 1, "en_drop_frame_timeout");
        tick(60);
        check("en_drop_fifo_level", fifo_q.size(), 1);
        check("en_drop_busy_after", busy, 1'b0);
        en = 1'b1;
        wait_frames(base + 2, "en_restore_timeout");

        tick(1);
        base = frames_done;
        push(tbl[1]); push(tbl[4]);
        wait_busy("rst_mid_busy");
        repeat (17) @(posedge clk);
        #2;
        check("pre_rst_tx_bit3", tx, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_frames(base + 1, "after_rst_timeout");

        tick(5);
        check("scoreboard_empty", sb.size(), 0);
        check("fifo_empty", fifo_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
